// File: rtl/perf_pkg.sv
// perf_pkg: register map, CTRL layout and bus FSM states
// shared by the performance-counter bank.
package perf_pkg;

  localparam logic [3:0] OFF_LO   = 4'h0;
  localparam logic [3:0] OFF_HI   = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;

  localparam logic [7:0] ADDR_GCTRL = 8'hF0;
  localparam logic [7:0] ADDR_OVF   = 8'hF4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_SEL    = 4;
  localparam int CTRL_IRQ_EN = 8;
  localparam int CTRL_OVF    = 9;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

endpackage

// File: rtl/perf_counter.sv
// perf_counter: one counter channel with its LO-read shadow,
// CTRL fields and sticky overflow flag.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_WIDTH = 64,
  parameter bit RST_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  input  logic                 i_wr_lo,
  input  logic                 i_wr_hi,
  input  logic                 i_wr_ctrl,
  input  logic                 i_rd_lo,
  input  logic [31:0]          i_wdata,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic [CNT_WIDTH-33:0] o_shadow,
  output logic                 o_en,
  output logic [3:0]           o_sel,
  output logic                 o_irq_en,
  output logic                 o_ovf
);

  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-33:0] r_shadow;
  logic                  r_en;
  logic [3:0]            r_sel;
  logic                  r_irq_en;
  logic                  r_ovf;
  logic                  w_wr;
  logic                  w_wrap;

  // a data write suppresses the same-edge increment
  assign w_wr   = i_wr_lo | i_wr_hi;
  assign w_wrap = i_inc & ~w_wr & (&r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_en     <= RST_EN;
      r_sel    <= '0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (i_wr_lo)
        r_cnt[31:0] <= i_wdata;
      if (i_wr_hi)
        r_cnt[CNT_WIDTH-1:32] <= i_wdata[CNT_WIDTH-33:0];
      if (i_inc & ~w_wr)
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (i_rd_lo)
        r_shadow <= r_cnt[CNT_WIDTH-1:32];
      if (i_wr_ctrl) begin
        r_en     <= i_wdata[CTRL_EN];
        r_sel    <= i_wdata[CTRL_SEL+:4];
        r_irq_en <= i_wdata[CTRL_IRQ_EN];
      end
      if (w_wrap)
        r_ovf <= 1'b1;
      else if (i_wr_ctrl & i_wdata[CTRL_OVF])
        r_ovf <= 1'b0;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_shadow = r_shadow;
  assign o_en     = r_en;
  assign o_sel    = r_sel;
  assign o_irq_en = r_irq_en;
  assign o_ovf    = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: event-selectable counter bank behind a
// 32-bit request/response register port with held response.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 64,
  parameter int NUM_EVT   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [7:0]         req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               irq
);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rdata;
  logic        r_freeze;
  logic        r_irq;

  logic        w_acc;
  logic        w_glob;
  logic [7:0]  w_waddr;
  logic [3:0]  w_off;
  logic [15:0] w_evt;
  logic [31:0] w_rdata;

  logic [NUM_CNT-1:0]    w_hit;
  logic [NUM_CNT-1:0]    w_inc;
  logic [NUM_CNT-1:0]    w_en;
  logic [NUM_CNT-1:0]    w_irq_en;
  logic [NUM_CNT-1:0]    w_ovf;
  logic [3:0]            w_sel    [NUM_CNT];
  logic [CNT_WIDTH-1:0]  w_cnt    [NUM_CNT];
  logic [CNT_WIDTH-33:0] w_shadow [NUM_CNT];

  assign w_acc   = req_valid & r_req_ready;
  assign w_waddr = {req_addr[7:2], 2'b00};
  assign w_off   = w_waddr[3:0];
  // the whole 0xF0 page belongs to the global registers
  assign w_glob  = &req_addr[7:4];
  assign w_evt   = 16'(evt);

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    assign w_hit[gi] = w_acc & ~w_glob &
                       (req_addr[7:4] == 4'(gi));
    assign w_inc[gi] = w_en[gi] & ~r_freeze &
                       w_evt[w_sel[gi]];

    perf_counter #(
      .CNT_WIDTH(CNT_WIDTH),
      .RST_EN   (gi == 0)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_inc    (w_inc[gi]),
      .i_wr_lo  (w_hit[gi] & req_write & (w_off == OFF_LO)),
      .i_wr_hi  (w_hit[gi] & req_write & (w_off == OFF_HI)),
      .i_wr_ctrl(w_hit[gi] & req_write & (w_off == OFF_CTRL)),
      .i_rd_lo  (w_hit[gi] & ~req_write & (w_off == OFF_LO)),
      .i_wdata  (req_wdata),
      .o_cnt    (w_cnt[gi]),
      .o_shadow (w_shadow[gi]),
      .o_en     (w_en[gi]),
      .o_sel    (w_sel[gi]),
      .o_irq_en (w_irq_en[gi]),
      .o_ovf    (w_ovf[gi])
    );
  end

  always_comb begin
    w_rdata = '0;
    if (w_waddr == ADDR_GCTRL) begin
      w_rdata = {31'b0, r_freeze};
    end else if (w_waddr == ADDR_OVF) begin
      w_rdata = 32'(w_ovf);
    end else if (!w_glob) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (req_addr[7:4] == 4'(i)) begin
          case (w_off)
            OFF_LO:   w_rdata = w_cnt[i][31:0];
            OFF_HI:   w_rdata = 32'(w_shadow[i]);
            OFF_CTRL: w_rdata = {22'b0, w_ovf[i], w_irq_en[i],
                                 w_sel[i], 3'b0, w_en[i]};
            default:  w_rdata = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (req_valid) begin
          r_state     <= RESP;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rdata     <= req_write ? '0 : w_rdata;
        end
        RESP: if (rsp_ready) begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_freeze <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_acc & req_write & (w_waddr == ADDR_GCTRL))
        r_freeze <= req_wdata[0];
      r_irq <= |(w_ovf & w_irq_en);
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign irq       = r_irq;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed table, corner sequences and
// random traffic checked against a behavioural bank model.
module tb_perf_counter_bank;

  localparam int NC = 4;
  localparam int W  = 64;
  localparam int NE = 8;
  localparam longint unsigned MAXV = {64{1'b1}} >> (64 - W);
  localparam longint unsigned HMSK = MAXV >> 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NE-1:0] evt;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [7:0]    req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          irq;

  always #5 clk = ~clk;

  perf_counter_bank #(
    .NUM_CNT  (NC),
    .CNT_WIDTH(W),
    .NUM_EVT  (NE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .evt      (evt),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .irq      (irq)
  );

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // behavioural model of the bank
  longint unsigned m_cnt [NC];
  longint unsigned m_shd [NC];
  bit              m_en  [NC];
  int              m_sel [NC];
  bit              m_ie  [NC];
  bit              m_ovf [NC];
  bit              m_frz;
  bit              m_busy;
  bit              m_irq;
  logic [31:0]     m_rdata;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int ci = int'(a[7:4]);
    int of = int'(a[3:2]);
    logic [31:0] v = '0;
    if (ci == 15) begin
      if (of == 0) v = {31'b0, m_frz};
      if (of == 1)
        for (int i = 0; i < NC; i++) v[i] = m_ovf[i];
      return v;
    end
    if (ci >= NC) return 32'd0;
    case (of)
      0: v = m_cnt[ci][31:0];
      1: v = m_shd[ci][31:0];
      2: v = {22'b0, m_ovf[ci], m_ie[ci], 4'(m_sel[ci]),
              3'b0, m_en[ci]};
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit          inc [NC];
    bit          irq_n;
    bit          acc;
    bit          wlo, whi, wct, rlo, wrap;
    int          ai, of;
    logic [15:0] ev16;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[i] = 0;
        m_shd[i] = 0;
        m_en[i]  = (i == 0);
        m_sel[i] = 0;
        m_ie[i]  = 1'b0;
        m_ovf[i] = 1'b0;
      end
      m_frz   = 1'b0;
      m_busy  = 1'b0;
      m_irq   = 1'b0;
      m_rdata = '0;
    end else begin
      ev16  = 16'(evt);
      irq_n = 1'b0;
      for (int i = 0; i < NC; i++) begin
        irq_n |= m_ovf[i] & m_ie[i];
        inc[i] = m_en[i] && !m_frz && (m_sel[i] < NE) &&
                 ev16[m_sel[i]];
      end
      acc = req_valid && !m_busy;
      ai  = int'(req_addr[7:4]);
      of  = int'(req_addr[3:2]);
      if (acc) m_rdata = req_write ? 32'd0 : m_read(req_addr);
      for (int i = 0; i < NC; i++) begin
        wlo  = acc && req_write && ai == i && of == 0;
        whi  = acc && req_write && ai == i && of == 1;
        wct  = acc && req_write && ai == i && of == 2;
        rlo  = acc && !req_write && ai == i && of == 0;
        wrap = 1'b0;
        if (rlo) m_shd[i] = m_cnt[i] >> 32;
        if (wlo)
          m_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF) |
                     64'(req_wdata);
        if (whi)
          m_cnt[i] = (m_cnt[i] & 64'hFFFF_FFFF) |
                     ((64'(req_wdata) & HMSK) << 32);
        if (!wlo && !whi && inc[i]) begin
          if (m_cnt[i] == MAXV) begin
            m_cnt[i] = 0;
            wrap = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (wct) begin
          m_en[i]  = req_wdata[0];
          m_sel[i] = int'(req_wdata[7:4]);
          m_ie[i]  = req_wdata[8];
        end
        if (wrap) m_ovf[i] = 1'b1;
        else if (wct && req_wdata[9]) m_ovf[i] = 1'b0;
      end
      if (acc && req_write && ai == 15 && of == 0)
        m_frz = req_wdata[0];
      m_irq = irq_n;
      if (acc) m_busy = 1'b1;
      else if (m_busy && rsp_ready) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_req_ready", 32'(req_ready), 32'(!m_busy));
      chk("mon_rsp_valid", 32'(rsp_valid), 32'(m_busy));
      chk("mon_rsp_rdata", rsp_rdata, m_rdata);
      chk("mon_irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic access(input bit w, input logic [7:0] a,
                        input logic [31:0] d,
                        output logic [31:0] rd);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("rsp_arrives", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
  endtask

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit w, logic [7:0] a,
                              logic [31:0] d, logic [31:0] e,
                              string nm);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.exp = e; v.nm = nm;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    vt.push_back(mk(0, 8'h00, 0, 32'd10, "c0_lo_10"));
    vt.push_back(mk(0, 8'h04, 0, 32'd0, "c0_hi_0"));
    vt.push_back(mk(0, 8'h08, 0, 32'h001, "c0_ctrl_rst"));
    vt.push_back(mk(0, 8'h03, 0, 32'd10, "addr_lsb_ign"));
    vt.push_back(mk(0, 8'h18, 0, 32'h000, "c1_ctrl_rst"));
    vt.push_back(mk(1, 8'h18, 32'hFFFF_FC31, 0, "wr_rsp_0"));
    vt.push_back(mk(0, 8'h18, 0, 32'h031, "c1_ctrl_mask"));
    vt.push_back(mk(1, 8'h18, 32'hFFFF_FFFF, 0, "wr_rsp_1"));
    vt.push_back(mk(0, 8'h18, 0, 32'h1F1, "c1_ctrl_all"));
    vt.push_back(mk(1, 8'h18, 32'h031, 0, "wr_rsp_2"));
    vt.push_back(mk(0, 8'h18, 0, 32'h031, "c1_ctrl_031"));
    vt.push_back(mk(1, 8'h50, 32'h1234, 0, "wr_oob"));
    vt.push_back(mk(0, 8'h50, 0, 32'd0, "rd_oob"));
    vt.push_back(mk(0, 8'h0C, 0, 32'd0, "rd_unmapped"));
    vt.push_back(mk(0, 8'hF0, 0, 32'd0, "gctrl_rst"));
    vt.push_back(mk(0, 8'hF4, 0, 32'd0, "ovf_rst"));
    vt.push_back(mk(1, 8'hF8, 32'hFFFF, 0, "wr_glob_unm"));
    vt.push_back(mk(0, 8'hF8, 0, 32'd0, "rd_glob_unm"));
    vt.push_back(mk(0, 8'h28, 0, 32'd0, "c2_ctrl_rst"));

    rst = 1'b1; evt = '0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    @(negedge clk);
    evt = 8'h01;
    repeat (10) @(negedge clk);
    evt = '0;

    foreach (vt[k]) begin
      access(vt[k].w, vt[k].a, vt[k].d, rd);
      chk(vt[k].nm, rd, vt[k].exp);
    end

    for (int k = 0; k < 5; k++) begin
      @(negedge clk); evt = 8'h08;
      @(negedge clk); evt = 8'hF7;
    end
    @(negedge clk); evt = '0;
    access(0, 8'h10, 0, rd); chk("c1_evt3_5", rd, 32'd5);

    access(1, 8'h10, 32'hFFFF_FFFE, rd);
    access(1, 8'h14, 32'hFFFF_FFFF, rd);
    access(1, 8'h18, 32'h131, rd);
    @(negedge clk); evt = 8'h08;
    @(negedge clk);
    @(negedge clk); evt = '0;
    chk("irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_rise", 32'(irq), 32'd1);
    access(0, 8'h10, 0, rd); chk("wrap_lo", rd, 32'd0);
    access(0, 8'h14, 0, rd); chk("wrap_hi", rd, 32'd0);
    access(0, 8'h18, 0, rd); chk("ovf_set", rd, 32'h331);
    access(0, 8'hF4, 0, rd); chk("ovf_reg", rd, 32'h2);
    access(1, 8'h18, 32'h331, rd);
    @(negedge clk);
    chk("irq_clear", 32'(irq), 32'd0);
    access(0, 8'h18, 0, rd); chk("ovf_clr", rd, 32'h131);

    access(1, 8'h28, 32'h091, rd);
    @(negedge clk); evt = 8'hFF;
    repeat (4) @(negedge clk);
    evt = '0;
    access(0, 8'h20, 0, rd); chk("sel_oob_nocnt", rd, 32'd0);

    access(1, 8'h00, 32'hFFFF_FFFE, rd);
    access(1, 8'h04, 32'h0, rd);
    evt = 8'h01;
    access(0, 8'h00, 0, rd); chk("coh_lo", rd, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    access(0, 8'h04, 0, rd); chk("coh_hi_shadow", rd, 32'd0);
    access(0, 8'h00, 0, rd);
    access(0, 8'h04, 0, rd); chk("coh_hi_next", rd, 32'd1);
    evt = '0;

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0;
    req_addr = 8'h18; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("stall_rdata0", rsp_rdata, 32'h131);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", rsp_rdata, 32'h131);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    rsp_ready = 1'b1;

    evt = 8'hFF;
    access(1, 8'hF0, 32'h1, rd);
    access(1, 8'h00, 32'h100, rd);
    repeat (5) @(negedge clk);
    access(0, 8'h00, 0, rd); chk("freeze_hold", rd, 32'h100);
    access(0, 8'hF0, 0, rd); chk("freeze_rd", rd, 32'h1);
    access(1, 8'hF0, 32'h0, rd);
    access(0, 8'h00, 0, rd); chk("freeze_resume", rd, 32'h101);
    access(0, 8'h10, 0, rd); chk("c1_off_rst", rd, 32'd0);
    evt = '0;

    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      evt       = NE'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = ($urandom_range(0, 2) == 0);
      req_write = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0)
        req_addr = 8'hF0 | 8'($urandom_range(0, 3) << 2);
      else
        req_addr = 8'($urandom_range(0, 5) << 4) |
                   8'($urandom_range(0, 3) << 2) |
                   8'($urandom_range(0, 3));
      case (req_addr[3:2])
        2'd0: req_wdata = ($urandom_range(0, 1) != 0) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                          : $urandom;
        2'd1: req_wdata = ($urandom_range(0, 1) != 0) ?
                          32'hFFFF_FFFF : $urandom;
        default: req_wdata = $urandom;
      endcase
      if (req_addr[7:4] == 4'hF)
        req_wdata = 32'($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    evt = '0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
